dsp_mac_pipe: RTL and testbench

Parametrised four-stage pre-add / multiply / post-add DSP slice: next generation of the team's fixed-function DSP block. Adds configurable operand widths, signed arithmetic, run-time per-sample opcode selection (including accumulate modes), a valid pipeline, correct C-operand alignment and a signed-overflow flag. Sits in the datapath between operand sources and downstream filters/accumulators.

---
 rtl/dsp_pkg.sv | 16 +
 rtl/dsp_delay_line.sv | 25 ++
 rtl/dsp_mac_pipe.sv | 133 +++++++++++++
 tb/tb_dsp_mac_pipe.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared opmode encoding and default widths for the DSP MAC slice
package dsp_pkg;

    localparam int DSP_AW = 18;
    localparam int DSP_BW = 18;
    localparam int DSP_CW = 48;
    localparam int DSP_PW = 48;

    typedef enum logic [1:0] {
        OP_ADD_C   = 2'b00,
        OP_SUB_C   = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } opmode_e;

endpackage

// File: rtl/dsp_delay_line.sv
// rtl/dsp_delay_line.sv - width/depth parametrised shift register with synchronous active-low clear
module dsp_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_sr [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - four-stage signed pre-add / multiply / post-add slice with accumulate and overflow flag
module dsp_mac_pipe
    import dsp_pkg::*;
#(
    parameter int AW = DSP_AW,
    parameter int BW = DSP_BW,
    parameter int CW = DSP_CW,
    parameter int PW = DSP_PW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [AW-1:0] A,
    input  logic signed [BW-1:0] B,
    input  logic signed [BW-1:0] D,
    input  logic signed [CW-1:0] C,
    input  logic                 pre_sub,
    input  logic [1:0]           opmode,
    output logic                 out_valid,
    output logic signed [PW-1:0] P,
    output logic                 ovf
);

    localparam int MW = AW + BW + 1;

    if (PW < MW) begin : g_chk_pw_m
        $error("dsp_mac_pipe: PW must be >= AW+BW+1");
    end
    if (PW < CW) begin : g_chk_pw_c
        $error("dsp_mac_pipe: PW must be >= CW");
    end

    // A, C, opmode and valid ride delay lines so they meet their own sample's M at stage 4
    logic signed [AW-1:0] w_a2;
    logic signed [CW-1:0] w_c3;
    logic [1:0]           w_op3;
    logic                 w_v3;

    dsp_delay_line #(.W(AW), .DEPTH(2)) u_dly_a  (.clk(clk), .rst_n(rst_n), .i_d(A),        .o_q(w_a2));
    dsp_delay_line #(.W(CW), .DEPTH(3)) u_dly_c  (.clk(clk), .rst_n(rst_n), .i_d(C),        .o_q(w_c3));
    dsp_delay_line #(.W(2),  .DEPTH(3)) u_dly_op (.clk(clk), .rst_n(rst_n), .i_d(opmode),   .o_q(w_op3));
    dsp_delay_line #(.W(1),  .DEPTH(3)) u_dly_v  (.clk(clk), .rst_n(rst_n), .i_d(in_valid), .o_q(w_v3));

    logic signed [BW-1:0] r1_b;
    logic signed [BW-1:0] r1_d;
    logic                 r1_sub;
    logic signed [BW:0]   r2_pre;
    logic signed [MW-1:0] r3_m;
    logic signed [PW-1:0] r_p;
    logic                 r_ovf;
    logic                 r_out_valid;

    logic signed [BW:0]   w_b_x;
    logic signed [BW:0]   w_d_x;
    logic signed [MW-1:0] w_a_x;
    logic signed [MW-1:0] w_pre_x;

    assign w_b_x   = {r1_b[BW-1], r1_b};
    assign w_d_x   = {r1_d[BW-1], r1_d};
    assign w_a_x   = {{(MW-AW){w_a2[AW-1]}}, w_a2};
    assign w_pre_x = {{AW{r2_pre[BW]}}, r2_pre};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_b   <= '0;
            r1_d   <= '0;
            r1_sub <= 1'b0;
            r2_pre <= '0;
            r3_m   <= '0;
        end else begin
            r1_b   <= B;
            r1_d   <= D;
            r1_sub <= pre_sub;
            r2_pre <= r1_sub ? (w_d_x - w_b_x) : (w_d_x + w_b_x);
            r3_m   <= w_a_x * w_pre_x;
        end
    end

    // Post-add runs one bit wider than P; disagreement of the top two bits is signed overflow
    logic signed [PW:0] w_m_x;
    logic signed [PW:0] w_c_x;
    logic signed [PW:0] w_p_x;
    logic signed [PW:0] w_lhs;
    logic signed [PW:0] w_rhs;
    logic signed [PW:0] w_sum;
    logic               w_sub;
    opmode_e            w_op3_e;

    assign w_m_x   = {{(PW+1-MW){r3_m[MW-1]}}, r3_m};
    assign w_c_x   = {{(PW+1-CW){w_c3[CW-1]}}, w_c3};
    assign w_p_x   = {r_p[PW-1], r_p};
    assign w_op3_e = opmode_e'(w_op3);

    always_comb begin
        w_lhs = w_m_x;
        w_rhs = w_c_x;
        w_sub = 1'b0;
        case (w_op3_e)
            OP_ADD_C:   w_sub = 1'b0;
            OP_SUB_C:   w_sub = 1'b1;
            OP_ACC_ADD: begin
                w_lhs = w_p_x;
                w_rhs = w_m_x;
            end
            OP_ACC_SUB: begin
                w_lhs = w_p_x;
                w_rhs = w_m_x;
                w_sub = 1'b1;
            end
            default:    w_sub = 1'b0;
        endcase
        w_sum = w_sub ? (w_lhs - w_rhs) : (w_lhs + w_rhs);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p         <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_v3;
            if (w_v3) begin
                r_p   <= w_sum[PW-1:0];
                r_ovf <= w_sum[PW] ^ w_sum[PW-1];
            end
        end
    end

    assign P         = r_p;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb/tb_dsp_mac_pipe.sv - directed table-driven bench for dsp_mac_pipe
module tb_dsp_mac_pipe;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic signed [17:0]  A;
    logic signed [17:0]  B;
    logic signed [17:0]  D;
    logic signed [47:0]  C;
    logic                pre_sub;
    logic [1:0]          opmode;
    logic                out_valid;
    logic signed [47:0]  P;
    logic                ovf;

    dsp_mac_pipe #(.AW(18), .BW(18), .CW(48), .PW(48)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .A(A), .B(B), .D(D), .C(C),
        .pre_sub(pre_sub), .opmode(opmode),
        .out_valid(out_valid), .P(P), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               vld;
        logic signed [17:0] a;
        logic signed [17:0] b;
        logic signed [17:0] d;
        logic signed [47:0] c;
        logic               sub;
        logic [1:0]         op;
        logic signed [47:0] exp_p;
        logic               exp_ovf;
    } vec_t;

    vec_t               q[$];
    int                 tests;
    int                 fails;
    logic signed [47:0] hold_p;
    logic               hold_ovf;

    localparam logic signed [47:0] MAXP = 48'sh7FFF_FFFF_FFFF;
    localparam logic signed [47:0] MINP = 48'sh8000_0000_0000;

    function automatic vec_t mk(input logic signed [17:0] a, input logic signed [17:0] b,
                                input logic signed [17:0] d, input logic signed [47:0] c,
                                input logic sub, input logic [1:0] op,
                                input logic signed [47:0] ep, input logic eo);
        vec_t v;
        v.vld = 1'b1; v.a = a; v.b = b; v.d = d; v.c = c;
        v.sub = sub; v.op = op; v.exp_p = ep; v.exp_ovf = eo;
        return v;
    endfunction

    function automatic vec_t idle();
        vec_t v;
        v.vld = 1'b0; v.a = '0; v.b = '0; v.d = '0; v.c = '0;
        v.sub = 1'b0; v.op = 2'b00; v.exp_p = '0; v.exp_ovf = 1'b0;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        logic [63:0] r64;
        if (v.vld) begin
            A = v.a; B = v.b; D = v.d; C = v.c;
            pre_sub = v.sub; opmode = v.op; in_valid = 1'b1;
        end else begin
            r64 = {$urandom(), $urandom()};
            A = 18'($urandom()); B = 18'($urandom()); D = 18'($urandom());
            C = r64[47:0]; pre_sub = 1'($urandom()); opmode = 2'($urandom());
            in_valid = 1'b0;
        end
    endtask

    task automatic check(input string name, input int idx, input logic ev,
                         input logic signed [47:0] ep, input logic eo);
        tests++;
        if (out_valid !== ev || P !== ep || ovf !== eo) begin
            fails++;
            $display("FAIL %s idx=%0d: got out_valid=%0b P=%0d ovf=%0b, expected out_valid=%0b P=%0d ovf=%0b",
                     name, idx, out_valid, P, ovf, ev, ep, eo);
        end
    endtask

    // Drives q back-to-back; sample t is visible at the 4th negedge after it is driven
    task automatic run_stream(input string name);
        int n;
        n = q.size();
        for (int t = 0; t < n + 4; t++) begin
            @(negedge clk);
            if (t >= 4 && q[t-4].vld) begin
                hold_p   = q[t-4].exp_p;
                hold_ovf = q[t-4].exp_ovf;
                check(name, t - 4, 1'b1, hold_p, hold_ovf);
            end else begin
                check(name, t - 4, 1'b0, hold_p, hold_ovf);
            end
            if (t < n) apply(q[t]);
            else       apply(idle());
        end
        q.delete();
    endtask

    initial begin
        tests = 0; fails = 0;
        hold_p = '0; hold_ovf = 1'b0;
        rst_n = 1'b0;
        apply(idle());

        for (int i = 0; i < 3; i++) begin
            apply(idle());
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("reset_hold", i, 1'b0, 48'sd0, 1'b0);
        end
        rst_n = 1'b1;
        apply(idle());
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_release", i, 1'b0, 48'sd0, 1'b0);
            apply(idle());
        end

        q.push_back(mk(18'sd3, 18'sd4, 18'sd5, 48'sd10, 1'b0, 2'b00, 48'sd37, 1'b0));
        q.push_back(mk(18'sd3, 18'sd4, 18'sd5, 48'sd10, 1'b1, 2'b01, -48'sd7, 1'b0));
        q.push_back(mk(-18'sd2, 18'sd1, -18'sd3, 48'sd0, 1'b1, 2'b00, 48'sd8, 1'b0));
        q.push_back(mk(18'sd0, 18'sd7, 18'sd9, 48'sd1, 1'b0, 2'b00, 48'sd1, 1'b0));
        q.push_back(mk(18'sd0, 18'sd7, 18'sd9, 48'sd2, 1'b1, 2'b00, 48'sd2, 1'b0));
        q.push_back(mk(18'sd0, 18'sd7, 18'sd9, 48'sd3, 1'b0, 2'b00, 48'sd3, 1'b0));
        q.push_back(mk(18'sd1, 18'sd0, 18'sd1, MAXP, 1'b0, 2'b00, MINP, 1'b1));
        q.push_back(mk(18'sd1, 18'sd0, 18'sd1, 48'sd0, 1'b0, 2'b00, 48'sd1, 1'b0));
        q.push_back(mk(-18'sd1, 18'sd0, 18'sd1, MINP, 1'b0, 2'b00, MAXP, 1'b1));
        q.push_back(mk(18'sd0, 18'sd0, 18'sd0, MINP, 1'b0, 2'b01, MINP, 1'b1));
        q.push_back(idle());
        q.push_back(mk(18'sh20000, 18'sh20000, 18'sh20000, 48'sd0, 1'b0, 2'b00,
                       48'sd34359738368, 1'b0));
        q.push_back(mk(18'sh1FFFF, 18'sh20000, 18'sh1FFFF, -48'sd5, 1'b1, 2'b01,
                       48'sd34359345158, 1'b0));
        q.push_back(idle());
        q.push_back(idle());
        run_stream("table");

        q.push_back(mk(18'sd0, 18'sd0, 18'sd0, 48'sd0, 1'b0, 2'b00, 48'sd0, 1'b0));
        for (int i = 1; i <= 5; i++)
            q.push_back(mk(18'sd1, 18'sd0, 18'sd2, 48'sd99, 1'b0, 2'b10, 48'(2 * i), 1'b0));
        q.push_back(idle());
        q.push_back(mk(18'sd1, 18'sd0, 18'sd2, 48'sd0, 1'b0, 2'b10, 48'sd12, 1'b0));
        q.push_back(idle());
        q.push_back(idle());
        q.push_back(mk(18'sd3, 18'sd0, 18'sd1, 48'sd0, 1'b0, 2'b11, 48'sd9, 1'b0));
        q.push_back(mk(-18'sd1, 18'sd2, 18'sd5, 48'sd0, 1'b1, 2'b10, 48'sd6, 1'b0));
        run_stream("accumulate");

        q.push_back(mk(18'sd0, 18'sd0, 18'sd0, MAXP, 1'b0, 2'b00, MAXP, 1'b0));
        q.push_back(mk(18'sd1, 18'sd0, 18'sd1, 48'sd0, 1'b0, 2'b10, MINP, 1'b1));
        q.push_back(mk(18'sd1, 18'sd0, 18'sd1, 48'sd0, 1'b0, 2'b11, MAXP, 1'b1));
        q.push_back(mk(18'sd1, 18'sd0, 18'sd1, 48'sd0, 1'b0, 2'b11, 48'sh7FFF_FFFF_FFFE, 1'b0));
        run_stream("acc_ovf");

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            apply(mk(18'sd1, 18'sd0, 18'sd2, 48'sd0, 1'b0, 2'b10, 48'sd0, 1'b0));
        end
        @(negedge clk);
        apply(idle());
        in_valid = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        hold_p = '0; hold_ovf = 1'b0;
        check("reset_mid", -1, 1'b0, 48'sd0, 1'b0);
        rst_n = 1'b1;
        apply(idle());
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_mid_flush", i, 1'b0, 48'sd0, 1'b0);
            apply(idle());
        end

        q.push_back(mk(18'sd1, 18'sd0, 18'sd2, 48'sd0, 1'b0, 2'b10, 48'sd2, 1'b0));
        q.push_back(mk(18'sd1, 18'sd0, 18'sd2, 48'sd0, 1'b0, 2'b10, 48'sd4, 1'b0));
        run_stream("acc_restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
